// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined adder/subtractor:
//     - operation mode encodings carried alongside each beat
//     - helpers that split an N-bit carry chain into STAGES segments
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic [1:0] ADD_WRAP = 2'b00;
    localparam logic [1:0] ADD_USAT = 2'b01;
    localparam logic [1:0] ADD_SSAT = 2'b10;
    localparam logic [1:0] SUB_WRAP = 2'b11;

    // Segment width: ceil(n / stages).
    function automatic int seg_width(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    // Lowest bit handled by segment k, clamped to n so that trailing segments
    // of an uneven split come out empty rather than out of range.
    function automatic int seg_lo(input int n, input int stages, input int k);
        int lo;
        lo = k * seg_width(n, stages);
        return (lo > n) ? n : lo;
    endfunction

    // Number of bits added by segment k (last one truncated, may be 0).
    function automatic int seg_len(input int n, input int stages, input int k);
        return seg_lo(n, stages, k + 1) - seg_lo(n, stages, k);
    endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// -----------------------------------------------------------------------------
// adder_pipe_seg
//   One carry-chain segment: a WK-bit adder with carry in/out, followed by a
//   valid bit and a PW-bit payload register that advance together on en.
//   The adder result is exposed combinationally; the parent decides what of it
//   goes into the payload (partial sum and carry, or the finished result).
//
//   Ports
//     clk, rst   clock, synchronous active-high reset
//     en         pipeline advance; register holds when low
//     valid_i    beat valid entering this segment
//     a_i, b_i   WK-bit operand slices
//     cin_i      carry into this slice
//     pay_i      payload to register
//     s_o, c_o   slice sum and carry out (combinational)
//     valid_o    registered valid
//     pay_o      registered payload
// -----------------------------------------------------------------------------
module adder_pipe_seg #(
    parameter int WK = 1,
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          valid_i,
    input  logic [WK-1:0] a_i,
    input  logic [WK-1:0] b_i,
    input  logic          cin_i,
    input  logic [PW-1:0] pay_i,
    output logic [WK-1:0] s_o,
    output logic          c_o,
    output logic          valid_o,
    output logic [PW-1:0] pay_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WK{1'b0}}, cin_i};

    // NOTE: sequential state uses non-blocking assignments so every segment
    // samples its neighbour's old value on the same edge.
    // NOTE: the payload is reset as well as the valid bit because the final
    // segment's payload drives sum/cout/ovf/tag_out, which must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            pay_o   <= '0;
        end else if (en) begin
            valid_o <= valid_i;
            pay_o   <= pay_i;
        end
    end

endmodule

// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//   Pipelined N-bit adder/subtractor with valid/ready on both sides. The carry
//   chain is cut into STAGES registered segments; each beat carries its own
//   mode and a user tag. Latency is STAGES advancing cycles, throughput one
//   beat per cycle while the consumer is ready.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     in_valid, in_ready   operand handshake
//     a, b                 N-bit operands
//     mode                 ADD_WRAP / ADD_USAT / ADD_SSAT / SUB_WRAP
//     tag_in               user tag, returned with the result
//     out_valid, out_ready result handshake
//     sum                  N-bit result (saturated in the saturating modes)
//     cout                 raw carry out of the MSB (subtract: 1 = no borrow)
//     ovf                  overflow for the selected mode
//     tag_out              tag of the current result beat
// -----------------------------------------------------------------------------
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int N      = 10,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    // Intermediate payload: {a, b-as-added, partial sum, carry, mode, tag}.
    localparam int MID_W = 3 * N + 3 + TAG_W;
    // Final payload: {sum, cout, ovf, tag}.
    localparam int FIN_W = N + 2 + TAG_W;

    // The whole pipeline moves as one; a stalled output freezes every stage,
    // so in_ready depends only on the output register and out_ready.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int  LO   = seg_lo(N, STAGES, k);
        localparam int  LEN  = seg_len(N, STAGES, k);
        localparam int  WK   = (LEN > 0) ? LEN : 1;
        localparam bit  LAST = (k == STAGES - 1);
        localparam int  PW   = LAST ? FIN_W : MID_W;

        logic             v_i;
        logic [N-1:0]     a_i;
        logic [N-1:0]     bx_i;
        logic [N-1:0]     part_i;
        logic             c_i;
        logic [1:0]       m_i;
        logic [TAG_W-1:0] t_i;

        if (k == 0) begin : g_src
            // Subtract is a + ~b + 1: invert b once here and seed the carry.
            assign v_i    = in_valid;
            assign a_i    = a;
            assign bx_i   = (mode == SUB_WRAP) ? ~b : b;
            assign part_i = '0;
            assign c_i    = (mode == SUB_WRAP);
            assign m_i    = mode;
            assign t_i    = tag_in;
        end else begin : g_src
            assign v_i = g_stage[k-1].v_q;
            assign {a_i, bx_i, part_i, c_i, m_i, t_i} = g_stage[k-1].pay_q;
        end

        logic [WK-1:0] s_seg;
        logic          c_seg;
        logic          v_q;
        logic [PW-1:0] pay_d;
        logic [PW-1:0] pay_q;

        adder_pipe_seg #(
            .WK (WK),
            .PW (PW)
        ) u_seg (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .valid_i (v_i),
            .a_i     (WK'(a_i >> LO)),
            .b_i     (WK'(bx_i >> LO)),
            .cin_i   (c_i),
            .pay_i   (pay_d),
            .s_o     (s_seg),
            .c_o     (c_seg),
            .valid_o (v_q),
            .pay_o   (pay_q)
        );

        // An empty trailing segment (uneven split) adds nothing: its slice
        // shifts out to zero and the incoming carry passes straight through.
        logic [N-1:0] part_o;
        logic         c_o;
        assign part_o = part_i | (N'(s_seg) << LO);
        assign c_o    = (LEN > 0) ? c_seg : c_i;

        if (LAST) begin : g_fin
            logic [N-1:0] sum_f;
            logic         ovf_f;
            logic         sovf;

            // NOTE: every variable gets a value before the case so no path
            // leaves one unassigned and a latch is never inferred.
            always_comb begin
                sovf  = (a_i[N-1] == bx_i[N-1]) && (part_o[N-1] != a_i[N-1]);
                sum_f = part_o;
                ovf_f = sovf;
                case (m_i)
                    ADD_USAT: begin
                        ovf_f = c_o;
                        if (c_o) sum_f = '1;
                    end
                    ADD_SSAT: begin
                        // Clamp toward the sign of A: +max or -max-1.
                        if (sovf) sum_f = a_i[N-1] ? {1'b1, {(N-1){1'b0}}}
                                                   : {1'b0, {(N-1){1'b1}}};
                    end
                    default: ;
                endcase
            end

            assign pay_d = {sum_f, c_o, ovf_f, t_i};
        end else begin : g_mid
            assign pay_d = {a_i, bx_i, part_o, c_o, m_i, t_i};
        end
    end

    assign out_valid                 = g_stage[STAGES-1].v_q;
    assign {sum, cout, ovf, tag_out} = g_stage[STAGES-1].pay_q;

endmodule
